// File: rtl/adder_wide_serial_ctrl_if.sv
// Bundle for the wide serial adder controller: upstream start handshake,
// downstream result handshake and the byte-wide bus to the registered adder.
//   start_valid/start_ready, op_a, op_b, cin_in : operation request
//   res_valid/res_ready, res_sum, res_cout       : wide result
//   add_a, add_b, add_cin / add_sum, add_cout    : to / from the 8-bit adder
//   busy                                         : controller not idle
// slave  : controller side.
// master : environment side (requester, consumer and the adder itself).
interface adder_wide_serial_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_in;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         busy;

  modport slave (
    input  start_valid, op_a, op_b, cin_in, add_sum, add_cout, res_ready,
    output start_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, busy
  );

  modport master (
    output start_valid, op_a, op_b, cin_in, add_sum, add_cout, res_ready,
    input  start_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, busy
  );
endinterface

// File: rtl/adder_wide_serial_ctrl.sv
// Serialises an NBYTES-wide addition onto a registered 8-bit adder with
// ADDER_LAT cycles of latency. Bytes go out LSB first; each byte's carry-out
// is fed back as the next byte's carry-in.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : adder_wide_serial_ctrl_if.slave (start handshake, adder bus,
//                result handshake, busy)
// Each byte costs one ISSUE cycle plus ADDER_LAT WAIT cycles, so the result
// appears NBYTES*(ADDER_LAT+1) cycles after the accepting edge.
module adder_wide_serial_ctrl #(
  parameter int NBYTES    = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adder_wide_serial_ctrl_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = $clog2(ADDER_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          cout_q;
  logic          accept, last_beat, last_byte;

  assign accept    = (state == IDLE) && bus.start_valid;
  // Adder output for the current byte is valid in the final WAIT cycle.
  assign last_beat = (state == WAIT) && (cnt == CW'(1));
  assign last_byte = (idx == IW'(NBYTES - 1));

  assign bus.res_sum  = sum_q;
  assign bus.res_cout = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d         = state;
    bus.start_ready = 1'b0;
    bus.res_valid   = 1'b0;
    bus.busy        = 1'b1;
    bus.add_a       = 8'h00;
    bus.add_b       = 8'h00;
    bus.add_cin     = 1'b0;
    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        bus.busy        = 1'b0;
        if (bus.start_valid) state_d = ISSUE;
      end
      ISSUE: begin
        bus.add_a   = a_q[idx*8 +: 8];
        bus.add_b   = b_q[idx*8 +: 8];
        bus.add_cin = carry;
        state_d     = WAIT;
      end
      WAIT: begin
        // Operands held for the whole adder latency so a multi-stage adder
        // never sees them change mid-flight.
        bus.add_a   = a_q[idx*8 +: 8];
        bus.add_b   = b_q[idx*8 +: 8];
        bus.add_cin = carry;
        if (cnt == CW'(1)) state_d = last_byte ? DONE : ISSUE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        a_q   <= bus.op_a;
        b_q   <= bus.op_b;
        carry <= bus.cin_in;
        idx   <= '0;
      end
      if (state == ISSUE)     cnt <= CW'(ADDER_LAT);
      else if (state == WAIT) cnt <= cnt - CW'(1);
      if (last_beat) begin
        sum_q[idx*8 +: 8] <= bus.add_sum;
        carry             <= bus.add_cout;
        if (last_byte) cout_q <= bus.add_cout;
        else           idx    <= idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_adder_wide_serial_ctrl.sv
// Bench for adder_wide_serial_ctrl: two instances (4 bytes / 1-cycle adder and
// 2 bytes / 2-cycle adder), each driving a behavioural registered adder.
// Expected results come from plain wide arithmetic on the operands.
module tb_adder_wide_serial_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  adder_wide_serial_ctrl_if #(.NBYTES(4)) b0();
  adder_wide_serial_ctrl_if #(.NBYTES(2)) b1();

  adder_wide_serial_ctrl #(.NBYTES(4), .ADDER_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  adder_wide_serial_ctrl #(.NBYTES(2), .ADDER_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // Registered 8-bit adders: one stage for u0, two stages for u1.
  logic [8:0] p1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) {b0.add_cout, b0.add_sum} <= 9'd0;
    else {b0.add_cout, b0.add_sum} <= {1'b0, b0.add_a} + {1'b0, b0.add_b} + {8'd0, b0.add_cin};

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1 <= 9'd0;
      {b1.add_cout, b1.add_sum} <= 9'd0;
    end else begin
      p1 <= {1'b0, b1.add_a} + {1'b0, b1.add_b} + {8'd0, b1.add_cin};
      {b1.add_cout, b1.add_sum} <= p1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] prev_sum0;
  logic        prev_cout0;

  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic c, input int bp);
    logic [32:0] exp;
    logic [63:0] mask, lo;
    int lat, j;
    exp = {1'b0, a} + {1'b0, b} + {32'd0, c};
    chk("s_rdy", 64'(b0.start_ready), 64'd1);
    b0.op_a = a; b0.op_b = b; b0.cin_in = c; b0.start_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs: the controller must work from its latched copy.
    b0.start_valid = 1'b0;
    b0.op_a = $urandom; b0.op_b = $urandom; b0.cin_in = 1'($urandom);
    chk("hold_sum", 64'(b0.res_sum), 64'(prev_sum0));
    chk("hold_cout", 64'(b0.res_cout), 64'(prev_cout0));
    lat = 0;
    while (!b0.res_valid && lat < 40) begin
      if (lat < 8) begin
        j    = lat / 2;
        mask = (64'd1 << (8 * j)) - 64'd1;
        lo   = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
        chk("add_a", 64'(b0.add_a), 64'(a >> (8 * j)) & 64'hFF);
        chk("add_b", 64'(b0.add_b), 64'(b >> (8 * j)) & 64'hFF);
        chk("add_cin", 64'(b0.add_cin), lo >> (8 * j));
        chk("busy", 64'(b0.busy), 64'd1);
        chk("s_rdy_busy", 64'(b0.start_ready), 64'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd8);
    chk("sum", 64'(b0.res_sum), 64'(exp[31:0]));
    chk("cout", 64'(b0.res_cout), 64'(exp[32]));
    for (int k = 0; k < bp; k++) begin
      b0.start_valid = (k == 0);
      b0.op_a = $urandom; b0.op_b = $urandom;
      @(negedge clk);
      chk("bp_valid", 64'(b0.res_valid), 64'd1);
      chk("bp_sum", 64'(b0.res_sum), 64'(exp[31:0]));
      chk("bp_cout", 64'(b0.res_cout), 64'(exp[32]));
      chk("bp_rdy", 64'(b0.start_ready), 64'd0);
    end
    b0.start_valid = 1'b0;
    b0.res_ready = 1'b1;
    @(negedge clk);
    b0.res_ready = 1'b0;
    chk("idle_valid", 64'(b0.res_valid), 64'd0);
    chk("idle_rdy", 64'(b0.start_ready), 64'd1);
    chk("idle_sum", 64'(b0.res_sum), 64'(exp[31:0]));
    prev_sum0  = exp[31:0];
    prev_cout0 = exp[32];
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
    chk("s_rdy1", 64'(b1.start_ready), 64'd1);
    b1.op_a = a; b1.op_b = b; b1.cin_in = c; b1.start_valid = 1'b1;
    @(negedge clk);
    b1.start_valid = 1'b0;
    lat = 0;
    while (!b1.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency1", 64'(lat), 64'd6);
    chk("sum1", 64'(b1.res_sum), 64'(exp[15:0]));
    chk("cout1", 64'(b1.res_cout), 64'(exp[16]));
    b1.res_ready = 1'b1;
    @(negedge clk);
    b1.res_ready = 1'b0;
    chk("idle1", 64'(b1.busy), 64'd0);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_rdy"},   64'(b0.start_ready), 64'd1);
    chk({tag, "_valid"}, 64'(b0.res_valid), 64'd0);
    chk({tag, "_sum"},   64'(b0.res_sum), 64'd0);
    chk({tag, "_cout"},  64'(b0.res_cout), 64'd0);
    chk({tag, "_adda"},  64'(b0.add_a), 64'd0);
    chk({tag, "_addb"},  64'(b0.add_b), 64'd0);
    chk({tag, "_addc"},  64'(b0.add_cin), 64'd0);
    chk({tag, "_busy"},  64'(b0.busy), 64'd0);
  endtask

  initial begin
    int seen;
    b0.start_valid = 0; b0.op_a = 0; b0.op_b = 0; b0.cin_in = 0; b0.res_ready = 0;
    b1.start_valid = 0; b1.op_a = 0; b1.op_b = 0; b1.cin_in = 0; b1.res_ready = 0;
    prev_sum0 = 32'd0; prev_cout0 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset0("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset0("post_rst");

    op0(32'h000000FF, 32'h00000001, 1'b0, 0);
    op0(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    op0(32'h12345678, 32'h87654321, 1'b0, 0);
    op0(32'hFFFFFFFF, 32'h00000001, 1'b0, 5);

    // Abort during byte 2, then confirm nothing completes.
    b0.op_a = 32'h11111111; b0.op_b = 32'h22222222; b0.cin_in = 1'b0;
    b0.start_valid = 1'b1;
    @(negedge clk);
    b0.start_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset0("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0.res_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (b0.res_valid) seen++;
    end
    b0.res_ready = 1'b0;
    chk("abort_no_valid", 64'(seen), 64'd0);
    prev_sum0 = 32'd0; prev_cout0 = 1'b0;
    op0(32'h00000001, 32'h00000001, 1'b0, 0);

    op0(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1);
    for (int i = 0; i < 20; i++)
      op0($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));

    op1(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 8; i++)
      op1(16'($urandom), 16'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
